// File: rtl/parity_seq.sv
// Sequenced parity checker: walks a captured word through one 3-input XOR slice
// per cycle, reports parity/mismatch over valid/ready and keeps a saturating error count.
module parity_seq #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_odd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_parity,
  output logic          out_error,
  output logic          busy,
  output logic [CW-1:0] err_count
);

  localparam int NCHUNK = (W + 2) / 3;
  localparam int SW     = 3 * NCHUNK;
  localparam int CNTW   = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic            mode_q, mode_d;
  logic            par_q, par_d;
  logic            err_q, err_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic            slice_out;

  // The one shared parity slice; the shift register is zero-padded to a multiple of 3.
  assign slice_out = shift_q[0] ^ shift_q[1] ^ shift_q[2];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    par_d     = par_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d        = '0;
          shift_d[W-1:0] = in_data;
          mode_d         = in_odd;
          acc_d          = 1'b0;
          cnt_d          = '0;
          state_d        = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_q ^ slice_out;
        shift_d = shift_q >> 3;
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(NCHUNK - 1)) begin
          par_d   = acc_q ^ slice_out;
          err_d   = acc_q ^ slice_out ^ mode_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (err_q && (err_cnt_q != {CW{1'b1}}))
            err_cnt_d = err_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      mode_q    <= 1'b0;
      par_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      par_q     <= par_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Result registers hold the last result outside DONE.
  assign out_parity = par_q;
  assign out_error  = err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_parity_seq.sv
// Directed bench for parity_seq: a W=8/CW=8 instance (index 0) and a W=3/CW=2 instance (index 1).
module tb_parity_seq;

  logic       clock;
  logic [1:0] rst_n;
  logic [1:0] in_valid, in_ready, in_odd, out_valid, out_ready, out_parity, out_error, busy;
  logic [7:0] in_data [2];
  logic [7:0] cnt8;
  logic [1:0] cnt3;
  logic [2:0] data3;

  int checks   = 0;
  int failures = 0;

  assign data3 = in_data[1][2:0];

  parity_seq #(.W(8), .CW(8)) u_w8 (
    .clock(clock), .reset(rst_n[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_odd(in_odd[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_parity(out_parity[0]),
    .out_error(out_error[0]), .busy(busy[0]), .err_count(cnt8)
  );

  parity_seq #(.W(3), .CW(2)) u_w3 (
    .clock(clock), .reset(rst_n[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(data3), .in_odd(in_odd[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_parity(out_parity[1]),
    .out_error(out_error[1]), .busy(busy[1]), .err_count(cnt3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int d);
    return (d == 0) ? 32'(cnt8) : 32'(cnt3);
  endfunction

  // One full transaction with latency, result and handshake checks.
  task automatic xact(input int d, input logic [7:0] data, input logic odd,
                      input logic ep, input logic ee, input int ec, input int nch);
    @(negedge clock);
    check_eq("idle_ready", in_ready[d], 1);
    in_valid[d] = 1'b1; in_data[d] = data; in_odd[d] = odd; out_ready[d] = 1'b0;
    @(negedge clock);
    in_valid[d] = 1'b0;
    check_eq("busy_run", busy[d], 1);
    check_eq("ready_run", in_ready[d], 0);
    for (int i = 1; i <= nch; i++) begin
      check_eq("no_early_valid", out_valid[d], 0);
      @(negedge clock);
    end
    check_eq("valid_latency", out_valid[d], 1);
    check_eq("parity", out_parity[d], 32'(ep));
    check_eq("error", out_error[d], 32'(ee));
    out_ready[d] = 1'b1;
    @(negedge clock);
    out_ready[d] = 1'b0;
    check_eq("valid_clear", out_valid[d], 0);
    check_eq("idle_after", busy[d], 0);
    check_eq("err_count", cnt_of(d), 32'(ec));
    $display("xact dut=%0d data=%02h odd=%0d parity=%0d error=%0d err_count=%0d",
             d, data, odd, out_parity[d], out_error[d], cnt_of(d));
  endtask

  initial begin
    logic [7:0]  par_tab;
    logic [31:0] cnt_tab [8];
    int          sat_tab [5];
    par_tab = 8'b1001_0110;
    cnt_tab = '{0, 1, 2, 2, 3, 3, 3, 3};
    sat_tab = '{1, 2, 3, 3, 3};

    rst_n = 2'b00;
    in_valid = 2'b11; in_odd = 2'b00; out_ready = 2'b00;
    in_data[0] = 8'hB1; in_data[1] = 8'h00;
    #1;
    check_eq("rst_valid", out_valid[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_parity", out_parity[0], 0);
    check_eq("rst_error", out_error[0], 0);
    check_eq("rst_cnt", cnt8, 0);
    check_eq("rst_ready", in_ready[0], 1);
    repeat (2) @(negedge clock);
    check_eq("rst_no_capture", busy, 0);
    in_valid = 2'b00;
    rst_n = 2'b11;

    // W=8 directed words
    xact(0, 8'b1011_0001, 1'b0, 1'b0, 1'b0, 0, 3);
    xact(0, 8'b1011_0001, 1'b1, 1'b0, 1'b1, 1, 3);
    xact(0, 8'h80,        1'b1, 1'b1, 1'b0, 1, 3);

    // Backpressure in DONE with an ignored in_valid
    @(negedge clock);
    in_valid[0] = 1'b1; in_data[0] = 8'h07; in_odd[0] = 1'b0;
    @(negedge clock);
    in_data[0] = 8'hFE; in_odd[0] = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", out_valid[0], 1);
      check_eq("bp_parity", out_parity[0], 1);
      check_eq("bp_error", out_error[0], 1);
      check_eq("bp_ready", in_ready[0], 0);
      @(negedge clock);
    end
    out_ready[0] = 1'b1; in_valid[0] = 1'b0;
    @(negedge clock);
    out_ready[0] = 1'b0;
    check_eq("bp_release_valid", out_valid[0], 0);
    check_eq("bp_release_ready", in_ready[0], 1);
    check_eq("bp_cnt", cnt8, 2);
    $display("xact dut=0 data=07 odd=0 backpressure err_count=%0d", cnt8);

    // Asynchronous reset after one RUN chunk
    @(negedge clock);
    in_valid[0] = 1'b1; in_data[0] = 8'hB1; in_odd[0] = 1'b1;
    @(negedge clock);
    in_valid[0] = 1'b0;
    @(negedge clock);
    check_eq("mid_busy", busy[0], 1);
    #2 rst_n[0] = 1'b0;
    #1;
    check_eq("arst_valid", out_valid[0], 0);
    check_eq("arst_busy", busy[0], 0);
    check_eq("arst_cnt", cnt8, 0);
    check_eq("arst_ready", in_ready[0], 1);
    @(negedge clock);
    rst_n[0] = 1'b1;
    xact(0, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 3);

    // W=3, CW=2: saturation then full sweep
    for (int i = 0; i < 5; i++)
      xact(1, 8'h00, 1'b1, 1'b0, 1'b1, sat_tab[i], 1);
    @(negedge clock);
    rst_n[1] = 1'b0;
    #1 check_eq("w3_rst_cnt", cnt3, 0);
    @(negedge clock);
    rst_n[1] = 1'b1;
    for (int v = 0; v < 8; v++)
      xact(1, 8'(v), 1'b0, par_tab[v], par_tab[v], int'(cnt_tab[v]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_seq.md
Name: parity_seq

Overview:
- Sequenced parity checker built around a single shared 3-input odd/even parity slice.
- Accepts a W-bit word over a valid/ready handshake and walks it through the slice 3 bits per cycle, accumulating the XOR.
- Reports the word's parity and a mismatch flag against the requested mode.
- Keeps a saturating mismatch counter for status readout. Sits between a producer of data words and a status/consumer interface.

Parameters:
W, 8, data word width in bits (W >= 1)
CW, 8, width of saturating error counter

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  block can accept a word
in_data  input  W  word to check
in_odd  input  1  expected parity mode: 1 = word must hold an odd count of ones, 0 = even
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_parity  output  1  XOR of all W bits of the accepted word
out_error  output  1  out_parity != latched in_odd
busy  output  1  state != IDLE
err_count  output  CW  number of results with out_error=1 that have been delivered, saturating

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; shift register, accumulator, chunk counter and mode latch are cleared.
  - out_valid=0, out_parity=0, out_error=0, busy=0, err_count=0.
  - in_ready follows state (1), but no capture occurs while reset is low.
- NCHUNK = ceil(W/3). Chunk counter width = clog2(NCHUNK+1).
- State machine IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid & in_ready: latch in_data into the shift register, latch in_odd, clear acc, set count=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the slice inputs are shift[0], shift[1], shift[2]. Bit positions >= W are fed as 0 (zero-pad last chunk).
  - acc <= acc ^ slice_out; shift >>= 3; count++.
  - When count reaches NCHUNK-1 on this edge, go to DONE.
  - Exactly NCHUNK cycles are spent in RUN.
- DONE:
  - out_valid=1; out_parity=acc (registered, stable); out_error=acc^mode.
  - Outputs hold while out_ready=0.
  - On an edge with out_ready=1: return to IDLE, clear out_valid. If out_error=1, err_count increments, unless it is already at 2^CW-1, in which case it holds.
- Latency: a word accepted at edge k gives out_valid=1 after edge k+NCHUNK. The first new accept is possible on the edge following the out_ready handshake.
- No overlap: in_ready=0 in RUN and DONE. in_valid/in_data changes during those states are ignored.
- out_parity/out_error are don't-care outside DONE but are driven to the last result (not X).
- W<=3: NCHUNK=1, single RUN cycle.
- in_valid asserted continuously: exactly one accept per IDLE visit.
- Reset asserted mid-RUN or in DONE: transaction aborted with no result. err_count clears. First accept is possible on the first edge after release.
- busy=1 exactly in RUN and DONE.

Test Plan:
- W=8, in_data=8'b1011_0001, in_odd=0, out_ready=1 → accept at edge 0, out_valid=1 after edge 3, out_parity=0, out_error=0; err_count stays 0.
- W=8, in_data=8'b1011_0001, in_odd=1 → out_parity=0, out_error=1; err_count=1 after the handshake edge. Then in_data=8'h80, in_odd=1 → parity 1, error 0, err_count stays 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid/out_parity/out_error stable, in_ready=0.
  - New in_valid ignored; raising out_ready returns to IDLE next edge.
- W=3 instance, sweep all 8 in_data values with in_odd=0 → each result after 1 RUN cycle; out_parity=1 for 3'b001, 010, 100, 111, else 0.
- Reset: pull reset low mid-RUN (after 1 chunk) → out_valid=0, busy=0, err_count=0 immediately (asynchronous). After release, an accepted word 8'hFF gives parity 0 with correct latency.
- CW=2, drive 5 mismatching transactions → err_count counts 1,2,3,3,3 (saturates, no wrap).
